// File: rtl/eth_mac_tx_if.sv
// Upstream byte-stream handshake into the Ethernet MII transmitter.
// The master drives bytes; the slave answers with a per-byte accept strobe.
interface eth_mac_tx_if;
    logic       in_txen;
    logic [7:0] in_txd;
    logic       in_txlast;
    logic       out_txready;

    modport master (output in_txen, output in_txd, output in_txlast, input out_txready);
    modport slave  (input in_txen, input in_txd, input in_txlast, output out_txready);
endinterface

// File: rtl/eth_mac_tx.sv
// Ethernet MII transmit MAC: preamble/SFD, nibble serialisation, zero padding,
// CRC-32 FCS, inter-frame gap and underrun signalling on TX_ER.
module eth_mac_tx #(
    parameter int MIN_FRAME = 60,
    parameter int IFG_BYTES = 12
) (
    input  logic          clk,
    input  logic          rst,
    eth_mac_tx_if.slave   up,
    output logic          mii_txen,
    output logic [3:0]    mii_txd,
    output logic          mii_txer,
    output logic          out_busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0, PREAMBLE = 3'd1, DATA = 3'd2, PAD = 3'd3, FCS = 3'd4, IFG = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE = 3'd0, ACT_START = 3'd1, ACT_ACCEPT = 3'd2, ACT_UNDER = 3'd3,
        ACT_PAD = 3'd4, ACT_FCS = 3'd5, ACT_IFG = 3'd6, ACT_IDLE = 3'd7
    } action_t;

    localparam logic [10:0] MIN_W    = 11'(MIN_FRAME);
    localparam logic [15:0] IFG_LAST = 16'(2 * IFG_BYTES - 1);

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    // The registers describe what is on the MII pins in the current cycle.
    state_t       state_r, state_n;
    logic [15:0]  tcnt_r, tcnt_n;
    logic [7:0]   byte_r, byte_n;
    logic         hi_r, hi_n;
    logic         last_r, last_n;
    logic         err_r, err_n;
    logic [10:0]  bcnt_r, bcnt_n;
    logic [31:0]  crc_r, crc_n;
    action_t      act_s;
    logic         ready_s;
    logic         txen_n, txer_n;
    logic [3:0]   txd_n;
    logic [31:0]  fcs_s;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            tcnt_r  <= 16'd0;
            byte_r  <= 8'd0;
            hi_r    <= 1'b0;
            last_r  <= 1'b0;
            err_r   <= 1'b0;
            bcnt_r  <= 11'd0;
            crc_r   <= 32'hFFFF_FFFF;
        end else begin
            state_r <= state_n;
            tcnt_r  <= tcnt_n;
            byte_r  <= byte_n;
            hi_r    <= hi_n;
            last_r  <= last_n;
            err_r   <= err_n;
            bcnt_r  <= bcnt_n;
            crc_r   <= crc_n;
        end
    end

    // Next-state: choose an action from the displayed state, then apply it
    always_comb begin
        act_s   = ACT_NONE;
        state_n = state_r;
        tcnt_n  = tcnt_r;
        byte_n  = byte_r;
        hi_n    = hi_r;
        last_n  = last_r;
        err_n   = err_r;
        bcnt_n  = bcnt_r;
        crc_n   = crc_r;

        case (state_r)
            IDLE:     act_s = up.in_txen ? ACT_START : ACT_NONE;
            PREAMBLE: begin
                if (tcnt_r != 16'd15) begin
                    tcnt_n = tcnt_r + 16'd1;
                end else begin
                    act_s = up.in_txen ? ACT_ACCEPT : ACT_UNDER;
                end
            end
            DATA: begin
                if (err_r) begin
                    act_s = ACT_IFG;
                end else if (!hi_r) begin
                    hi_n = 1'b1;
                end else if (!last_r) begin
                    act_s = up.in_txen ? ACT_ACCEPT : ACT_UNDER;
                end else begin
                    act_s = (bcnt_r < MIN_W) ? ACT_PAD : ACT_FCS;
                end
            end
            PAD: begin
                if (!hi_r) begin
                    hi_n = 1'b1;
                end else begin
                    act_s = (bcnt_r < MIN_W) ? ACT_PAD : ACT_FCS;
                end
            end
            FCS: begin
                if (tcnt_r != 16'd7) begin
                    tcnt_n = tcnt_r + 16'd1;
                end else begin
                    act_s = ACT_IFG;
                end
            end
            IFG: begin
                if (tcnt_r != IFG_LAST) begin
                    tcnt_n = tcnt_r + 16'd1;
                end else begin
                    // a pending frame starts straight out of the gap
                    act_s = up.in_txen ? ACT_START : ACT_IDLE;
                end
            end
            default:  act_s = ACT_IDLE;
        endcase

        case (act_s)
            ACT_START: begin
                state_n = PREAMBLE;
                tcnt_n  = 16'd0;
                bcnt_n  = 11'd0;
                crc_n   = 32'hFFFF_FFFF;
                hi_n    = 1'b0;
                last_n  = 1'b0;
                err_n   = 1'b0;
            end
            ACT_ACCEPT: begin
                state_n = DATA;
                byte_n  = up.in_txd;
                hi_n    = 1'b0;
                last_n  = up.in_txlast;
                bcnt_n  = sat_inc(bcnt_r);
                crc_n   = crc_byte(crc_r, up.in_txd);
            end
            ACT_UNDER: begin
                state_n = DATA;
                err_n   = 1'b1;
            end
            ACT_PAD: begin
                state_n = PAD;
                byte_n  = 8'h00;
                hi_n    = 1'b0;
                bcnt_n  = sat_inc(bcnt_r);
                crc_n   = crc_byte(crc_r, 8'h00);
            end
            ACT_FCS: begin
                state_n = FCS;
                tcnt_n  = 16'd0;
            end
            ACT_IFG: begin
                state_n = IFG;
                tcnt_n  = 16'd0;
                err_n   = 1'b0;
            end
            ACT_IDLE: state_n = IDLE;
            default:  state_n = state_r;
        endcase
    end

    // Outputs: accept strobe and busy from current state, pin values for the next cycle
    always_comb begin
        ready_s = ((state_r == PREAMBLE) && (tcnt_r == 16'd15)) ||
                  ((state_r == DATA) && hi_r && !last_r && !err_r);
        up.out_txready = ready_s;
        out_busy = (state_r != IDLE);
        fcs_s  = ~crc_n;
        txen_n = 1'b0;
        txd_n  = 4'h0;
        txer_n = 1'b0;
        case (state_n)
            PREAMBLE: begin
                txen_n = 1'b1;
                txd_n  = (tcnt_n == 16'd15) ? 4'hD : 4'h5;
            end
            DATA: begin
                txen_n = 1'b1;
                if (err_n) begin
                    txer_n = 1'b1;
                    txd_n  = 4'h0;
                end else begin
                    txd_n  = hi_n ? byte_n[7:4] : byte_n[3:0];
                end
            end
            PAD:     txen_n = 1'b1;
            FCS: begin
                txen_n = 1'b1;
                txd_n  = fcs_s[{tcnt_n[2:0], 2'b00} +: 4];
            end
            default: txen_n = 1'b0;
        endcase
    end

    // MII output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mii_txen <= 1'b0;
            mii_txd  <= 4'h0;
            mii_txer <= 1'b0;
        end else begin
            mii_txen <= txen_n;
            mii_txd  <= txd_n;
            mii_txer <= txer_n;
        end
    end

endmodule

// File: tb/tb_eth_mac_tx.sv
// Scoreboard bench for eth_mac_tx: one instance with padding disabled, one with defaults.
module tb_eth_mac_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       in_txen;
    logic [7:0] in_txd;
    logic       in_txlast;

    always #5 clk = ~clk;

    eth_mac_tx_if if0 ();
    eth_mac_tx_if if1 ();

    assign if0.in_txen   = in_txen & ~sel;
    assign if1.in_txen   = in_txen & sel;
    assign if0.in_txd    = in_txd;
    assign if1.in_txd    = in_txd;
    assign if0.in_txlast = in_txlast;
    assign if1.in_txlast = in_txlast;

    logic       m0_txen, m0_txer, b0, m1_txen, m1_txer, b1;
    logic [3:0] m0_txd, m1_txd;

    eth_mac_tx #(.MIN_FRAME(0), .IFG_BYTES(12)) u0 (
        .clk(clk), .rst(rst), .up(if0.slave),
        .mii_txen(m0_txen), .mii_txd(m0_txd), .mii_txer(m0_txer), .out_busy(b0));

    eth_mac_tx u1 (
        .clk(clk), .rst(rst), .up(if1.slave),
        .mii_txen(m1_txen), .mii_txd(m1_txd), .mii_txer(m1_txer), .out_busy(b1));

    logic       o_txen, o_txer, o_busy, o_ready;
    logic [3:0] o_txd;
    assign o_txen  = sel ? m1_txen : m0_txen;
    assign o_txd   = sel ? m1_txd  : m0_txd;
    assign o_txer  = sel ? m1_txer : m0_txer;
    assign o_busy  = sel ? b1      : b0;
    assign o_ready = sel ? if1.out_txready : if0.out_txready;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] sb_q[$];
    bit         sb_en = 1'b1;
    int         hi_q[$];
    int         lo_q[$];
    int         busy_q[$];
    int         hi_cnt = 0, lo_cnt = 0, busy_cnt = 0;
    bit         prev_en = 1'b0, lo_valid = 1'b0, busy_track = 1'b0;
    logic [7:0] frame[128];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0);
        end
        return c;
    endfunction

    task automatic push_frame(input int n, input bit underrun, input int minf);
        logic [31:0] crc;
        logic [31:0] fcs;
        int          cnt;
        crc = 32'hFFFF_FFFF;
        cnt = 0;
        for (int i = 0; i < 15; i++) sb_q.push_back(5'h05);
        sb_q.push_back(5'h0D);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back({1'b0, frame[i][3:0]});
            sb_q.push_back({1'b0, frame[i][7:4]});
            crc = crc_model(crc, frame[i]);
            cnt++;
        end
        if (underrun) begin
            sb_q.push_back(5'h10);
        end else begin
            while (cnt < minf) begin
                sb_q.push_back(5'h00);
                sb_q.push_back(5'h00);
                crc = crc_model(crc, 8'h00);
                cnt++;
            end
            fcs = ~crc;
            for (int k = 0; k < 8; k++) sb_q.push_back({1'b0, fcs[4*k +: 4]});
        end
    endtask

    // Monitor: scoreboard pops plus run-length bookkeeping, sampled mid-cycle.
    initial begin
        logic [4:0] exp;
        forever begin
            @(negedge clk);
            if (o_txen) begin
                if (sb_en) begin
                    if (sb_q.size() == 0) begin
                        check_val("sb_extra", 32'(sb_q.size()), 32'd1);
                    end else begin
                        exp = sb_q.pop_front();
                        check_val("nibble", {27'd0, o_txer, o_txd}, {27'd0, exp});
                    end
                end
                if (!prev_en && lo_valid) lo_q.push_back(lo_cnt);
                hi_cnt++;
            end else begin
                check_val("txer_idle", {31'd0, o_txer}, 32'd0);
                if (prev_en) begin
                    hi_q.push_back(hi_cnt);
                    hi_cnt = 0; lo_cnt = 0; busy_cnt = 0;
                    lo_valid = 1'b1; busy_track = 1'b1;
                end
                lo_cnt++;
                if (busy_track) begin
                    if (o_busy) begin
                        busy_cnt++;
                    end else begin
                        busy_q.push_back(busy_cnt);
                        busy_track = 1'b0;
                    end
                end
            end
            prev_en = o_txen;
        end
    end

    task automatic clear_track();
        sb_q.delete(); hi_q.delete(); lo_q.delete(); busy_q.delete();
        hi_cnt = 0; lo_valid = 1'b0; busy_track = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_txen = 1'b0; in_txlast = 1'b0; in_txd = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        clear_track();
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        @(negedge clk);
        while (!o_ready && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (!o_ready) check_val("ready_timeout", {31'd0, o_ready}, 32'd1);
    endtask

    task automatic send_frame(input int n, input bit underrun, input bit keep_en, input int minf);
        push_frame(n, underrun, minf);
        in_txen = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_txd    = frame[i];
            in_txlast = (i == n - 1) && !underrun;
            wait_ready();
            @(posedge clk);
            #1;
        end
        in_txlast = 1'b0;
        if (underrun || !keep_en) in_txen = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while (o_busy && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check_val("idle_timeout", {31'd0, o_busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_runs(input string tag, input int idx, input int hi_exp, input int busy_exp);
        check_val({tag, "_hi_n"}, 32'(hi_q.size()), 32'(idx + 1));
        if (hi_q.size() > idx) check_val({tag, "_hi_len"}, 32'(hi_q[idx]), 32'(hi_exp));
        check_val({tag, "_busy_n"}, 32'(busy_q.size()), 32'd1);
        if (busy_q.size() > 0) check_val({tag, "_ifg"}, 32'(busy_q[0]), 32'(busy_exp));
        check_val({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel = 1'b0; in_txen = 1'b0; in_txd = 8'h00; in_txlast = 1'b0;
        do_reset();
        @(negedge clk);
        check_val("reset_pins", {27'd0, o_txen, o_txd, o_txer, o_ready, o_busy}, 32'd0);

        // No padding, "123456789": 16 + 18 + 8 nibbles, then 24-cycle gap.
        for (int i = 0; i < 9; i++) frame[i] = 8'h31 + 8'(i);
        send_frame(9, 1'b0, 1'b0, 0);
        wait_idle();
        check_runs("check", 0, 42, 24);

        // Default parameters: single byte padded out to 60 bytes.
        sel = 1'b1;
        do_reset();
        @(negedge clk);
        check_val("reset_pins1", {27'd0, o_txen, o_txd, o_txer, o_ready, o_busy}, 32'd0);
        frame[0] = 8'hAB;
        send_frame(1, 1'b0, 1'b0, 60);
        wait_idle();
        check_runs("pad", 0, 144, 24);

        // Back-to-back: 60-byte frame (no pad) then 64-byte frame, in_txen held.
        clear_track();
        for (int i = 0; i < 60; i++) frame[i] = 8'($urandom_range(0, 255));
        send_frame(60, 1'b0, 1'b1, 60);
        for (int i = 0; i < 64; i++) frame[i] = 8'($urandom_range(0, 255));
        send_frame(64, 1'b0, 1'b0, 60);
        wait_idle();
        check_runs("b2b", 1, 152, 24);
        if (hi_q.size() > 0) check_val("b2b_hi0", 32'(hi_q[0]), 32'd144);
        check_val("b2b_lo_n", 32'(lo_q.size()), 32'd1);
        if (lo_q.size() > 0) check_val("b2b_gap", 32'(lo_q[0]), 32'd24);

        // Underrun after 10 bytes: error nibble, no FCS, gap, then idle.
        clear_track();
        for (int i = 0; i < 10; i++) frame[i] = 8'hC0 + 8'(i);
        send_frame(10, 1'b1, 1'b0, 60);
        wait_idle();
        check_runs("underrun", 0, 37, 24);

        // Reset during DATA, then a clean 64-byte frame.
        clear_track();
        sb_en = 1'b0;
        in_txen = 1'b1; in_txd = 8'h5A; in_txlast = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check_val("pre_rst_txen", {31'd0, o_txen}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        in_txen = 1'b0;
        @(negedge clk);
        check_val("rst_abort", {30'd0, o_txen, o_busy}, 32'd0);
        repeat (3) @(negedge clk);
        clear_track();
        sb_en = 1'b1;
        for (int i = 0; i < 64; i++) frame[i] = 8'(i * 3 + 1);
        send_frame(64, 1'b0, 1'b0, 60);
        wait_idle();
        check_runs("after_rst", 0, 152, 24);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/eth_mac_tx.md
ETH_MAC_TX -- requirements
Module: eth_mac_tx

Interface
REQ-001 Parameter MIN_FRAME, default 60, minimum byte count before FCS; shorter payloads are zero-padded up to it.
REQ-002 Parameter IFG_BYTES, default 12, inter-frame gap in byte times; each byte time is 2 clocks.
REQ-003 clk  input  1  MII transmit clock, one nibble per rising edge; single clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_txen  input  1  upstream byte valid.
REQ-006 in_txd  input  8  upstream byte.
REQ-007 in_txlast  input  1  marks the last byte of the frame; sampled only on an accepted byte.
REQ-008 out_txready  output  1  byte accept strobe; a transfer occurs when in_txen and out_txready are both 1 on a rising edge.
REQ-009 mii_txen  output  1  MII TX_EN.
REQ-010 mii_txd  output  4  MII TXD nibble.
REQ-011 mii_txer  output  1  MII TX_ER.
REQ-012 out_busy  output  1  high from frame start through the end of the IFG.

Function
REQ-013 States: IDLE, PREAMBLE, DATA, PAD, FCS, IFG; mii_txen, mii_txd and mii_txer are registered outputs.
REQ-014 IDLE: mii_txen=0, mii_txd=0, out_txready=0; in_txen=1 on edge T moves to PREAMBLE; no byte is consumed.
REQ-015 PREAMBLE: cycles T+1..T+16 drive mii_txen=1 with mii_txd=0x5 fifteen times, then 0xD (SFD 0xD5, low nibble first).
REQ-016 out_txready=1 combinationally in the SFD cycle and in every DATA cycle that shows a high nibble, until the in_txlast byte is accepted; 0 in all other cycles.
REQ-017 Accepted byte: low nibble on mii_txd in the next cycle, high nibble in the cycle after; the stream is gap-free when upstream keeps in_txen=1.
REQ-018 Byte counter is 11 bits, cleared at frame start, incremented per transmitted payload or pad byte, saturates at 2047; no maximum length is enforced.
REQ-019 After the in_txlast byte's high nibble: go to PAD if count < MIN_FRAME, else to FCS.
REQ-020 PAD emits 0x00 bytes (2 nibbles each) until count = MIN_FRAME, then goes to FCS; MIN_FRAME=0 disables padding.
REQ-021 CRC-32 (IEEE 802.3) uses reflected polynomial 0xEDB88320 and init 0xFFFFFFFF.
REQ-022 CRC coverage: every payload and pad byte, processed LSB first; preamble and SFD are excluded.
REQ-023 FCS is the bitwise complement of the CRC, sent as 8 nibbles, least-significant nibble first, with mii_txen=1.
REQ-024 IFG: mii_txen=0 for 2*IFG_BYTES cycles, out_txready=0, in_txen ignored; then IDLE.
REQ-025 A frame pending at the end of the IFG starts on the next edge per REQ-014.
REQ-026 Underrun (out_txready=1 and in_txen=0) response, next cycle: mii_txen=1, mii_txer=1, mii_txd=0 for exactly one cycle.
REQ-027 After an underrun: no pad and no FCS; go directly to IFG.
REQ-028 mii_txer=0 at all other times.
REQ-029 out_busy=1 in every state except IDLE.

Reset
REQ-030 On an edge with rst=1: state=IDLE; mii_txen, mii_txd, mii_txer and out_txready are 0; counters are cleared; CRC is reinitialised.
REQ-031 Reset mid-frame aborts immediately with no FCS and no IFG; the next frame starts normally after rst falls.
REQ-032 rst has priority over all other inputs.

Verification
REQ-033 MIN_FRAME=0, payload ASCII "123456789" -> 16 preamble/SFD nibbles, 18 data nibbles, FCS nibbles 6,2,9,3,4,F,B,C (CRC 0xCBF43926), then 24 cycles mii_txen=0.
REQ-034 Default params, single byte 0xAB with last -> data nibbles B,A, 59 zero pad bytes, FCS over 60 bytes; mii_txen high for exactly 144 consecutive cycles.
REQ-035 Two back-to-back frames with in_txen held -> exactly 24 cycles mii_txen=0 between frames; second preamble starts the cycle after the IFG.
REQ-036 in_txen dropped while out_txready=1 mid-payload -> one cycle mii_txer=1 with mii_txen=1, no FCS, 24-cycle IFG, out_busy=0 afterwards.
REQ-037 rst=1 during DATA -> mii_txen=0 and out_busy=0 on the next cycle; a following 64-byte frame produces a correct FCS.
REQ-038 Upstream asserts in_txlast on byte 60 -> no PAD state; FCS immediately follows byte 60.
